// File: rtl/ttio_sched_pkg.sv
// Shared types and helpers for the time-triggered IO scheduler.
// Timestamps are free-running tick counts, so every comparison is wrap-safe.
package ttio_sched_pkg;

  localparam int unsigned TS_W          = 32;
  localparam logic [1:0]  ICB_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_CPL  = 2'd3
  } state_t;

  // A timestamp is due once (now - ts) is non-negative as a signed value.
  function automatic logic ts_due(input logic [TS_W-1:0] now, input logic [TS_W-1:0] ts);
    logic [TS_W-1:0] diff;
    diff = now - ts;
    return ~diff[TS_W-1];
  endfunction

  // True when timestamp a lies strictly before timestamp b.
  function automatic logic ts_before(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    logic [TS_W-1:0] diff;
    diff = a - b;
    return diff[TS_W-1];
  endfunction

endpackage

// File: rtl/ttio_sched_pick.sv
// Selects the earliest due, idle slot; ties resolve to the lowest index.
module ttio_sched_pick
  import ttio_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [TS_W-1:0]  i_now,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_inflight,
  input  logic [TS_W-1:0]  i_time [DEPTH],
  output logic             o_found_c,
  output logic [IDX_W-1:0] o_idx_c
);

  logic [DEPTH-1:0] w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [TS_W-1:0]  w_best_time;

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_cand[i] = i_valid[i] & ~i_inflight[i] & ts_due(i_now, i_time[i]);
    end
  end

  // Strict "before" keeps the earlier index on equal timestamps.
  always_comb begin
    w_found     = 1'b0;
    w_idx       = '0;
    w_best_time = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_cand[i] && (!w_found || ts_before(i_time[i], w_best_time))) begin
        w_found     = 1'b1;
        w_idx       = IDX_W'(i);
        w_best_time = i_time[i];
      end
    end
  end

  assign o_found_c = w_found;
  assign o_idx_c   = w_idx;

endmodule

// File: rtl/ttio_sched.sv
// Time-triggered IO scheduler: buffers timestamped loads/stores and releases
// each onto the ICB once the shared timer reaches it, one transaction at a time.
module ttio_sched
  import ttio_sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ITAG_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TS_W-1:0]              timer_now,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [TS_W-1:0]              req_time,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic                         req_read,
  input  logic [XLEN-1:0]              req_wdata,
  input  logic [ITAG_W-1:0]            req_itag,
  input  logic                         flush,
  output logic                         icb_cmd_valid,
  input  logic                         icb_cmd_ready,
  output logic [ADDR_W-1:0]            icb_cmd_addr,
  output logic                         icb_cmd_read,
  output logic [XLEN-1:0]              icb_cmd_wdata,
  output logic [XLEN/8-1:0]            icb_cmd_wmask,
  output logic [1:0]                   icb_cmd_size,
  input  logic                         icb_rsp_valid,
  output logic                         icb_rsp_ready,
  input  logic                         icb_rsp_err,
  input  logic [XLEN-1:0]              icb_rsp_rdata,
  output logic                         cpl_valid,
  input  logic                         cpl_ready,
  output logic [XLEN-1:0]              cpl_rdata,
  output logic                         cpl_err,
  output logic [ITAG_W-1:0]            cpl_itag,
  output logic                         cpl_late,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic                         busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_inflight;
  logic [TS_W-1:0]   r_time  [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [XLEN-1:0]   r_wdata [DEPTH];
  logic [ITAG_W-1:0] r_itag  [DEPTH];
  logic [DEPTH-1:0]  r_read;
  logic [DEPTH-1:0]  r_late;

  state_t            r_state;
  logic [IDX_W-1:0]  r_sel;
  logic              r_req_ready;
  logic [CNT_W-1:0]  r_pend_cnt;
  logic              r_busy;
  logic              r_cmd_valid;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic              r_cmd_read;
  logic [XLEN-1:0]   r_cmd_wdata;
  logic              r_rsp_ready;
  logic              r_cpl_valid;
  logic [XLEN-1:0]   r_cpl_rdata;
  logic              r_cpl_err;
  logic [ITAG_W-1:0] r_cpl_itag;
  logic              r_cpl_late;

  logic              w_found;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_accept;
  logic              w_launch;
  logic              w_cpl_done;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [DEPTH-1:0]  w_infl_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  ttio_sched_pick #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_now      (timer_now),
    .i_valid    (r_valid),
    .i_inflight (r_inflight),
    .i_time     (r_time),
    .o_found_c  (w_found),
    .o_idx_c    (w_pick_idx)
  );

  always_comb begin
    w_free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // A launch in the flush cycle would hand out a slot that is being dropped.
  assign w_accept   = req_valid & r_req_ready;
  assign w_launch   = (r_state == ST_IDLE) & w_found & ~flush;
  assign w_cpl_done = r_cpl_valid & cpl_ready;

  // Flush first, then completion free, then the new accept, so an accept in
  // the flush cycle survives.
  always_comb begin
    w_valid_nxt = r_valid;
    w_infl_nxt  = r_inflight;
    if (flush) w_valid_nxt = r_valid & r_inflight;
    if (w_cpl_done) begin
      w_valid_nxt[r_sel] = 1'b0;
      w_infl_nxt[r_sel]  = 1'b0;
    end
    if (w_launch) w_infl_nxt[w_pick_idx] = 1'b1;
    if (w_accept) w_valid_nxt[w_free_idx] = 1'b1;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_inflight  <= '0;
      r_req_ready <= 1'b1;
      r_pend_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_inflight  <= w_infl_nxt;
      r_req_ready <= ~&w_valid_nxt;
      r_pend_cnt  <= w_cnt_nxt;
      r_busy      <= |w_valid_nxt;
    end
  end

  // Slot payload needs no reset; the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_time[w_free_idx]  <= req_time;
      r_addr[w_free_idx]  <= req_addr;
      r_read[w_free_idx]  <= req_read;
      r_wdata[w_free_idx] <= req_wdata;
      r_itag[w_free_idx]  <= req_itag;
      r_late[w_free_idx]  <= ts_due(timer_now, req_time);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_read  <= 1'b0;
      r_cmd_wdata <= '0;
      r_rsp_ready <= 1'b0;
      r_cpl_valid <= 1'b0;
      r_cpl_rdata <= '0;
      r_cpl_err   <= 1'b0;
      r_cpl_itag  <= '0;
      r_cpl_late  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_sel       <= w_pick_idx;
            r_cmd_addr  <= r_addr[w_pick_idx];
            r_cmd_read  <= r_read[w_pick_idx];
            r_cmd_wdata <= r_wdata[w_pick_idx];
            r_cpl_itag  <= r_itag[w_pick_idx];
            r_cpl_late  <= r_late[w_pick_idx];
            // Misaligned word access never reaches the bus.
            if (r_addr[w_pick_idx][1:0] != 2'b00) begin
              r_cpl_valid <= 1'b1;
              r_cpl_err   <= 1'b1;
              r_cpl_rdata <= '0;
              r_state     <= ST_CPL;
            end else begin
              r_cmd_valid <= 1'b1;
              r_state     <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (icb_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (icb_rsp_valid) begin
            r_rsp_ready <= 1'b0;
            r_cpl_valid <= 1'b1;
            r_cpl_rdata <= r_cmd_read ? icb_rsp_rdata : '0;
            r_cpl_err   <= icb_rsp_err;
            r_state     <= ST_CPL;
          end
        end
        ST_CPL: begin
          if (cpl_ready) begin
            r_cpl_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign icb_cmd_valid = r_cmd_valid;
  assign icb_cmd_addr  = r_cmd_addr;
  assign icb_cmd_read  = r_cmd_read;
  assign icb_cmd_wdata = r_cmd_wdata;
  assign icb_cmd_wmask = '1;
  assign icb_cmd_size  = ICB_SIZE_WORD;
  assign icb_rsp_ready = r_rsp_ready;
  assign cpl_valid     = r_cpl_valid;
  assign cpl_rdata     = r_cpl_rdata;
  assign cpl_err       = r_cpl_err;
  assign cpl_itag      = r_cpl_itag;
  assign cpl_late      = r_cpl_late;
  assign pend_cnt      = r_pend_cnt;
  assign busy          = r_busy;

endmodule
